// File: rtl/reset_sequencer.sv
// reset_sequencer
// Issues the per-domain reset requests for the downstream reset synchronizers.
// After power-on reset, a soft-reset request, or loss of clock lock, every
// output is held asserted for HOLD_CYCLES cycles of stable lock. The outputs
// are then released one at a time in ascending index order, STAGE_GAP cycles
// apart. done is raised STAGE_GAP cycles after the last release.
//
// A soft-reset request or loss of lock at any time re-asserts every output on
// the next edge and restarts the sequence. All outputs come directly from
// flops.
module reset_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               lock,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               busy,
    output logic               done
);

    // The counter only has to reach the larger of the two terminal counts,
    // so it can never wrap.
    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             abort;

    // A request or an untrustworthy clock restarts the whole sequence.
    // This takes priority over any terminal count seen in the same cycle.
    assign abort = req || !lock;

    // Sequencer FSM: hold, staged release, completion. Outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (abort) begin
            // All bits re-assert together on one edge; this step is never
            // sequenced.
            state   <= ST_ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_out <= '1;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    if (cnt == HOLD_LAST) begin
                        // The hold time has elapsed, so release domain 0.
                        state   <= ST_RELEASE;
                        rst_out <= {{(NUM_OUT-1){1'b1}}, 1'b0} & '1;
                        cnt     <= '0;
                        idx     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            // The final gap has run out and the sequence is
                            // complete.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Releases are strictly ascending. Shifting the
                            // mask clears the lowest still-asserted bit, which
                            // is bit idx+1.
                            rst_out <= rst_out << 1;
                            idx     <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    rst_out <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end

                default: begin
                    // An unreachable encoding falls back to the safe state.
                    state   <= ST_ASSERT;
                    cnt     <= '0;
                    idx     <= '0;
                    rst_out <= '1;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer.
// DUT a uses the default parameters (4 outputs, hold 16, gap 8).
// DUT b uses NUM_OUT=1, HOLD_CYCLES=1, STAGE_GAP=1.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       lock;
    logic [3:0] rst_out;
    logic       busy;
    logic       done;

    logic       rst_b;
    logic [0:0] rst_out_b;
    logic       busy_b;
    logic       done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT(4),
        .HOLD_CYCLES(16),
        .STAGE_GAP(8)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .req(req),
        .lock(lock),
        .rst_out(rst_out),
        .busy(busy),
        .done(done)
    );

    reset_sequencer #(
        .NUM_OUT(1),
        .HOLD_CYCLES(1),
        .STAGE_GAP(1)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .req(1'b0),
        .lock(1'b1),
        .rst_out(rst_out_b),
        .busy(busy_b),
        .done(done_b)
    );

    // Expected rst_out n edges into an undisturbed sequence.
    // Bit i falls at edge 16 + 8*i.
    function automatic logic [3:0] exp_rst(input int n);
        logic [3:0] v;
        v = 4'hF;
        for (int i = 0; i < 4; i++)
            if (n >= 16 + 8 * i) v[i] = 1'b0;
        return v;
    endfunction

    // done rises at edge 16 + 4*8 = 48.
    function automatic logic exp_done(input int n);
        return (n >= 48);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance one edge and compare DUT a against a sequence n edges in.
    task automatic step_chk(input string tag, input int n);
        tick();
        check($sformatf("%s n=%0d rst_out", tag, n), 32'(rst_out), 32'(exp_rst(n)));
        check($sformatf("%s n=%0d busy", tag, n), 32'(busy), 32'(!exp_done(n)));
        check($sformatf("%s n=%0d done", tag, n), 32'(done), 32'(exp_done(n)));
    endtask

    // Pulse rst across one edge; the next edge is then edge 1.
    task automatic restart;
        req  = 1'b0;
        lock = 1'b1;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        req   = 1'b0;
        lock  = 1'b1;
        tick();
        tick();

        // Reset state
        check("reset rst_out", 32'(rst_out), 32'hF);
        check("reset busy", 32'(busy), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset_b rst_out", 32'(rst_out_b), 32'd1);
        check("reset_b busy", 32'(busy_b), 32'd1);
        check("reset_b done", 32'(done_b), 32'd0);

        // Power-on sequence with lock held high; DUT b runs alongside
        rst   = 1'b0;
        rst_b = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            step_chk("poweron", e);
            if (e == 1) begin
                check("minimal e1 rst_out", 32'(rst_out_b), 32'd0);
                check("minimal e1 done", 32'(done_b), 32'd0);
                check("minimal e1 busy", 32'(busy_b), 32'd1);
            end
            if (e == 2) begin
                check("minimal e2 done", 32'(done_b), 32'd1);
                check("minimal e2 busy", 32'(busy_b), 32'd0);
            end
        end

        // lock low sampled at edges 10..12 restarts the hold; release at 28
        restart();
        for (int e = 1; e <= 40; e++) begin
            lock = !(e >= 10 && e <= 12);
            step_chk("lockdrop", (e <= 12) ? e : e - 12);
        end
        lock = 1'b1;

        // 1-cycle req at edge 28 while rst_out=1100
        restart();
        for (int e = 1; e <= 60; e++) begin
            req = (e == 28);
            step_chk("reqpulse", (e < 28) ? e : e - 28);
        end
        req = 1'b0;

        // Asynchronous rst mid-RELEASE, observed before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("async rst_out", 32'(rst_out), 32'hF);
        check("async busy", 32'(busy), 32'd1);
        check("async done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;

        // req level held for 20 cycles while in DONE
        for (int e = 1; e <= 90; e++) begin
            req = (e >= 49 && e <= 68);
            step_chk("reqlevel", (e < 49) ? e : ((e <= 68) ? 0 : e - 68));
        end
        req = 1'b0;

        // Simultaneous events: req at the hold terminal, lock loss at the
        // final-gap terminal
        restart();
        for (int e = 1; e <= 82; e++) begin
            req  = (e == 16);
            lock = !(e == 64);
            step_chk("simul", (e < 16) ? e : ((e < 64) ? e - 16 : e - 64));
        end
        req  = 1'b0;
        lock = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
